prog_loader: RTL and testbench
==============================

# prog_loader

Boot-time program loader sitting directly upstream of the `risc` core. It accepts a byte stream (from a host or UART front-end) on a valid/ready handshake, assembles bytes into instruction words, writes them into the core's instruction memory from address 0, and holds the core in reset until a complete, checksum-verified image is loaded. On success it releases the core; on any error it keeps the core in reset until the next `rst`.

## Interface
- `ADDR_W`, 8: instruction memory address width; DEPTH = 2^ADDR_W words.
- `DATA_W`, 16: instruction word width; must be a multiple of 8; BYTES = DATA_W/8.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_data`  in  8  stream byte.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  loader accepts a byte; transfer when `in_valid && in_ready` at a rising edge.
- `imem_we`  out  1  instruction memory write strobe, one cycle per word.
- `imem_addr`  out  ADDR_W  write address.
- `imem_wdata`  out  DATA_W  write data.
- `cpu_rst`  out  1  reset to `risc`; high until successful load.
- `done`  out  1  image loaded and verified (sticky).
- `err`  out  1  load failed (sticky).
- `words_loaded`  out  ADDR_W+1  count of words written so far.

## Operation
- Stream format: COUNT_LO, COUNT_HI (16-bit word count N, little-endian), then N×BYTES payload bytes, then one CHK byte.
- Word assembly little-endian: first payload byte of a word -> bits [7:0], last -> bits [DATA_W-1:DATA_W-8].
- Checksum: running XOR of every accepted byte from COUNT_LO through the last payload byte; CHK must equal it.
- States: HDR_LO -> HDR_HI -> DATA -> CHK -> DONE; any state may go to ERR.
  - HDR_LO: accept byte as N[7:0], start XOR.
  - HDR_HI: accept N[15:8]. If N > DEPTH -> ERR. If N == 0 -> CHK. Else -> DATA.
  - DATA: accept bytes; byte index counter 0..BYTES-1; on last byte of a word, issue write at address = words_loaded, increment words_loaded; after word N -> CHK.
  - CHK: accept one byte; equal to XOR -> DONE, else -> ERR.
  - DONE: `done`=1, `cpu_rst`=0. ERR: `err`=1, `cpu_rst`=1. Both terminal; exit only via `rst`.
- `in_ready` = 1 in HDR_LO, HDR_HI, DATA, CHK; 0 in DONE, ERR. Never depends combinationally on `in_valid`.
- Cycles with `in_valid`=0 stall the FSM without side effects; no timeout.
- N == DEPTH is legal (fills memory exactly); words_loaded reaches DEPTH, hence ADDR_W+1 bits.

## Timing
- Reset values: `in_ready`=0 during `rst`, 1 from the first edge after release (state HDR_LO); `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `cpu_rst`=1, `done`=0, `err`=0, `words_loaded`=0, XOR=0.
- Throughput: one byte per cycle sustained.
- Write latency: `imem_we`, `imem_addr`, `imem_wdata` are registered; asserted for exactly one cycle, the cycle after the edge accepting the word's last byte. `words_loaded` updates on the same edge.
- Release: `cpu_rst` falls and `done` rises on the edge after the edge accepting a matching CHK byte; the final word write always precedes or coincides with that edge's preceding cycle, so memory is complete before the core leaves reset.
- ERR on oversize N is entered on the edge after HDR_HI acceptance; no writes occur.
- Checksum-fail: already-written words remain in memory; `cpu_rst` stays 1.
- `rst` mid-load: all outputs return to reset values immediately (asynchronous); any in-flight `imem_we` is dropped; next load restarts at HDR_LO, address 0.

## Test plan
- Normal load, DATA_W=16: bytes 02 00 34 12 78 56 0A back-to-back -> writes addr0=0x1234, addr1=0x5678 (one-cycle `imem_we` each), `words_loaded`=2, `done`=1, `cpu_rst`=0 one edge after 0A accepted.
- Backpressure gaps: same stream with `in_valid` low for 3 cycles between each byte -> identical writes and result; no extra `imem_we`.
- Zero-length: 00 00 00 -> no writes, `done`=1; with 00 00 01 -> `err`=1, `cpu_rst`=1.
- Oversize (ADDR_W=8): 01 01 -> `err`=1 after HDR_HI, `in_ready`=0, no writes; full image 00 01 + 512 bytes + correct CHK -> 256 writes, `words_loaded`=256, `done`=1.
- Bad checksum: 01 00 CD AB FF (correct is 0x67) -> addr0=0xABCD written, then `err`=1, `cpu_rst` stays 1, `in_ready`=0.
- Reset mid-load: assert `rst` after 03 00 11 22 accepted -> outputs at reset values asynchronously; then 01 00 EF BE 50 -> addr0=0xBEEF, `words_loaded`=1, `done`=1.

Source files
------------

// File: rtl/prog_loader_if.sv
// Boot loader signal bundle: host byte stream in, instruction-memory writes and
// core reset/status out. The host side uses "master"; the loader uses "slave".
interface prog_loader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;
  logic              cpu_rst;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   words_loaded;

  modport master (
    output in_data, in_valid,
    input  in_ready, imem_we, imem_addr, imem_wdata, cpu_rst, done, err, words_loaded
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, imem_we, imem_addr, imem_wdata, cpu_rst, done, err, words_loaded
  );
endinterface

// File: rtl/prog_loader.sv
// Boot-time program loader: parses COUNT/payload/CHK byte stream, writes words to
// instruction memory from address 0 and releases the core only on a verified image.
module prog_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic           clk,
  input  logic           rst,
  prog_loader_if.slave   bus
);

  localparam int             BYTES    = DATA_W / 8;
  localparam int             IDX_W    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);
  localparam logic [16:0]    DEPTH    = 17'(1 << ADDR_W);

  typedef enum logic [2:0] {
    S_HDR_LO,
    S_HDR_HI,
    S_DATA,
    S_CHK,
    S_DONE,
    S_ERR
  } state_e;

  state_e            state_q, state_d;
  logic              inReady_q;
  logic [15:0]       count_q;
  logic [7:0]        chk_q;
  logic [IDX_W-1:0]  byteIdx_q;
  logic [DATA_W-1:0] asm_q;
  logic [ADDR_W:0]   words_q;
  logic              imemWe_q;
  logic [ADDR_W-1:0] imemAddr_q;
  logic [DATA_W-1:0] imemWdata_q;
  logic              cpuRst_q;
  logic              done_q;
  logic              err_q;

  logic              xfer;
  logic [16:0]       countHdr;
  logic [DATA_W-1:0] wordNext;
  logic              wordDone;
  logic [ADDR_W:0]   wordsInc;
  logic              lastWord;

  // Next-state decode; bytes shift in from the top so the first byte ends in [7:0].
  always_comb begin
    xfer     = bus.in_valid && inReady_q;
    countHdr = {1'b0, bus.in_data, count_q[7:0]};
    wordNext = asm_q >> 8;
    wordNext[DATA_W-1 -: 8] = bus.in_data;
    wordDone = (byteIdx_q == LAST_IDX);
    wordsInc = words_q + 1'b1;
    lastWord = (17'(wordsInc) == {1'b0, count_q});
    state_d  = state_q;
    if (xfer) begin
      case (state_q)
        S_HDR_LO: state_d = S_HDR_HI;
        S_HDR_HI: begin
          if (countHdr > DEPTH)       state_d = S_ERR;
          else if (countHdr == '0)    state_d = S_CHK;
          else                        state_d = S_DATA;
        end
        S_DATA:   if (wordDone && lastWord) state_d = S_CHK;
        S_CHK:    state_d = (bus.in_data == chk_q) ? S_DONE : S_ERR;
        default:  state_d = state_q;
      endcase
    end
  end

  // Status outputs follow the registered state, so done/err/cpu_rst lag entry by one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_HDR_LO;
      inReady_q   <= 1'b0;
      count_q     <= '0;
      chk_q       <= '0;
      byteIdx_q   <= '0;
      asm_q       <= '0;
      words_q     <= '0;
      imemWe_q    <= 1'b0;
      imemAddr_q  <= '0;
      imemWdata_q <= '0;
      cpuRst_q    <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      inReady_q <= (state_d != S_DONE) && (state_d != S_ERR);
      imemWe_q  <= 1'b0;
      done_q    <= (state_q == S_DONE);
      err_q     <= (state_q == S_ERR);
      cpuRst_q  <= (state_q != S_DONE);
      if (xfer) begin
        case (state_q)
          S_HDR_LO: begin
            count_q[7:0] <= bus.in_data;
            chk_q        <= bus.in_data;
          end
          S_HDR_HI: begin
            count_q[15:8] <= bus.in_data;
            chk_q         <= chk_q ^ bus.in_data;
            byteIdx_q     <= '0;
          end
          S_DATA: begin
            chk_q <= chk_q ^ bus.in_data;
            asm_q <= wordNext;
            if (wordDone) begin
              byteIdx_q   <= '0;
              imemWe_q    <= 1'b1;
              imemAddr_q  <= words_q[ADDR_W-1:0];
              imemWdata_q <= wordNext;
              words_q     <= wordsInc;
            end else begin
              byteIdx_q <= byteIdx_q + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.in_ready     = inReady_q;
  assign bus.imem_we      = imemWe_q;
  assign bus.imem_addr    = imemAddr_q;
  assign bus.imem_wdata   = imemWdata_q;
  assign bus.cpu_rst      = cpuRst_q;
  assign bus.done         = done_q;
  assign bus.err          = err_q;
  assign bus.words_loaded = words_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: table vectors, hand-written timing sequences
// and randomized images compared against a stream-level reference model.
module tb_prog_loader;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int BYTES  = DATA_W / 8;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef logic [ADDR_W+DATA_W-1:0] wr_t;
  typedef logic [7:0] byteq_t[$];

  typedef struct {
    int          len;
    logic [7:0]  b[8];
    int          gap;
    bit          expDone;
    bit          expErr;
    int          expWords;
    int          expWrites;
    logic [15:0] w0;
    logic [15:0] w1;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  wr_t  wrQ[$];
  wr_t  expQ[$];
  bit   mDone;
  bit   mErr;
  int   mWords;

  prog_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  prog_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Every write strobe seen on the memory bus, sampled mid-cycle
  always @(negedge clk) begin
    if (bus.imem_we) wrQ.push_back({bus.imem_addr, bus.imem_wdata});
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  // Reference model: interprets the image format directly from the byte list
  function automatic void model(input byteq_t s);
    int n;
    logic [7:0] x;
    logic [DATA_W-1:0] word;
    expQ.delete();
    mDone  = 1'b0;
    mErr   = 1'b0;
    mWords = 0;
    n = int'(s[0]) + (int'(s[1]) << 8);
    if (n > DEPTH) begin
      mErr = 1'b1;
      return;
    end
    x = 8'h00;
    for (int i = 0; i < 2 + n * BYTES; i++) x = x ^ s[i];
    for (int w = 0; w < n; w++) begin
      word = '0;
      for (int k = 0; k < BYTES; k++)
        word = word | (DATA_W'(s[2 + w * BYTES + k]) << (8 * k));
      expQ.push_back({ADDR_W'(w), word});
    end
    mWords = n;
    if (s[2 + n * BYTES] == x) mDone = 1'b1;
    else                       mErr  = 1'b1;
  endfunction

  task automatic resetDut();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic sendByte(input logic [7:0] b);
    int budget;
    budget = 50;
    while (!bus.in_ready && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL readyTimeout actual=0 required=1");
    end else begin
      bus.in_data  = b;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic runStream(input byteq_t s, input int gap);
    for (int i = 0; i < s.size(); i++) begin
      sendByte(s[i]);
      if (i != s.size() - 1) repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input byteq_t s, input int gap);
    resetDut();
    wrQ.delete();
    runStream(s, gap);
  endtask

  task automatic checkWrites();
    checkOutput("writeCount", wrQ.size(), expQ.size());
    for (int i = 0; i < wrQ.size() && i < expQ.size(); i++)
      checkOutput($sformatf("write%0d", i), wrQ[i], expQ[i]);
  endtask

  task automatic checkFinal();
    checkOutput("done", bus.done, mDone);
    checkOutput("err", bus.err, mErr);
    checkOutput("cpuRst", bus.cpu_rst, !mDone);
    checkOutput("wordsLoaded", bus.words_loaded, mWords);
    checkOutput("inReadyTerminal", bus.in_ready, 1'b0);
    checkOutput("imemWeIdle", bus.imem_we, 1'b0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "InReady"}, bus.in_ready, 1'b0);
    checkOutput({tag, "ImemWe"}, bus.imem_we, 1'b0);
    checkOutput({tag, "ImemAddr"}, bus.imem_addr, 0);
    checkOutput({tag, "ImemWdata"}, bus.imem_wdata, 0);
    checkOutput({tag, "CpuRst"}, bus.cpu_rst, 1'b1);
    checkOutput({tag, "Done"}, bus.done, 1'b0);
    checkOutput({tag, "Err"}, bus.err, 1'b0);
    checkOutput({tag, "Words"}, bus.words_loaded, 0);
  endtask

  vec_t   vecs[6];
  byteq_t s;

  initial begin
    int n;
    int gap;
    logic [7:0] x;
    logic [7:0] v;

    vecs[0] = '{len: 7, b: '{8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h0A, 8'h00}, gap: 0,
                expDone: 1, expErr: 0, expWords: 2, expWrites: 2, w0: 16'h1234, w1: 16'h5678};
    vecs[1] = '{len: 7, b: '{8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h0A, 8'h00}, gap: 3,
                expDone: 1, expErr: 0, expWords: 2, expWrites: 2, w0: 16'h1234, w1: 16'h5678};
    vecs[2] = '{len: 3, b: '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, gap: 0,
                expDone: 1, expErr: 0, expWords: 0, expWrites: 0, w0: 16'h0000, w1: 16'h0000};
    vecs[3] = '{len: 3, b: '{8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, gap: 1,
                expDone: 0, expErr: 1, expWords: 0, expWrites: 0, w0: 16'h0000, w1: 16'h0000};
    vecs[4] = '{len: 2, b: '{8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, gap: 0,
                expDone: 0, expErr: 1, expWords: 0, expWrites: 0, w0: 16'h0000, w1: 16'h0000};
    vecs[5] = '{len: 5, b: '{8'h01, 8'h00, 8'hCD, 8'hAB, 8'hFF, 8'h00, 8'h00, 8'h00}, gap: 0,
                expDone: 0, expErr: 1, expWords: 1, expWrites: 1, w0: 16'hABCD, w1: 16'h0000};

    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;

    // Asynchronous reset values, then in_ready rising on the first edge after release
    #2 rst = 1'b1;
    #1 checkResetValues("rstAsync");
    repeat (2) @(posedge clk);
    #1 checkOutput("rstHeldInReady", bus.in_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1 checkOutput("rstReleasedInReady", bus.in_ready, 1'b0);
    @(posedge clk);
    #1 checkOutput("firstEdgeInReady", bus.in_ready, 1'b1);

    // Cycle-exact write strobe and release timing
    resetDut();
    wrQ.delete();
    sendByte(8'h02);
    sendByte(8'h00);
    sendByte(8'h34);
    sendByte(8'h12);
    checkOutput("w0We", bus.imem_we, 1'b1);
    checkOutput("w0Addr", bus.imem_addr, 0);
    checkOutput("w0Data", bus.imem_wdata, 16'h1234);
    checkOutput("w0Words", bus.words_loaded, 1);
    @(posedge clk);
    #1 checkOutput("w0WeOneCycle", bus.imem_we, 1'b0);
    sendByte(8'h78);
    sendByte(8'h56);
    checkOutput("w1We", bus.imem_we, 1'b1);
    checkOutput("w1Addr", bus.imem_addr, 1);
    checkOutput("w1Data", bus.imem_wdata, 16'h5678);
    checkOutput("w1Words", bus.words_loaded, 2);
    sendByte(8'h0A);
    checkOutput("chkEdgeDone", bus.done, 1'b0);
    checkOutput("chkEdgeCpuRst", bus.cpu_rst, 1'b1);
    checkOutput("chkEdgeInReady", bus.in_ready, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("releaseDone", bus.done, 1'b1);
    checkOutput("releaseCpuRst", bus.cpu_rst, 1'b0);

    // Reset mid-load drops the in-flight write; the next load starts over at address 0
    resetDut();
    wrQ.delete();
    sendByte(8'h03);
    sendByte(8'h00);
    sendByte(8'h11);
    sendByte(8'h22);
    checkOutput("inflightWe", bus.imem_we, 1'b1);
    #2 rst = 1'b1;
    #1 checkResetValues("midLoad");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    wrQ.delete();
    s = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'h50};
    model(s);
    runStream(s, 0);
    checkWrites();
    checkFinal();
    checkOutput("reloadBeef", bus.imem_wdata, 16'hBEEF);

    // Table vectors with hand-derived expectations
    for (int t = 0; t < 6; t++) begin
      s.delete();
      for (int k = 0; k < vecs[t].len; k++) s.push_back(vecs[t].b[k]);
      expQ.delete();
      if (vecs[t].expWrites > 0) expQ.push_back({8'd0, vecs[t].w0});
      if (vecs[t].expWrites > 1) expQ.push_back({8'd1, vecs[t].w1});
      mDone  = vecs[t].expDone;
      mErr   = vecs[t].expErr;
      mWords = vecs[t].expWords;
      applyStimulus(s, vecs[t].gap);
      checkWrites();
      checkFinal();
    end

    // Full memory image, N == DEPTH
    s.delete();
    s.push_back(8'h00);
    s.push_back(8'h01);
    x = 8'h01;
    for (int i = 0; i < DEPTH * BYTES; i++) begin
      v = 8'($urandom);
      s.push_back(v);
      x = x ^ v;
    end
    s.push_back(x);
    model(s);
    applyStimulus(s, 0);
    checkWrites();
    checkFinal();

    // Randomized images: short payloads, occasional oversize headers and bad checksums
    for (int it = 0; it < 20; it++) begin
      s.delete();
      if (it % 7 == 3) begin
        n = 257 + $urandom_range(0, 1000);
        s.push_back(n[7:0]);
        s.push_back(n[15:8]);
      end else begin
        n = $urandom_range(0, 6);
        s.push_back(n[7:0]);
        s.push_back(n[15:8]);
        x = n[7:0] ^ n[15:8];
        for (int i = 0; i < n * BYTES; i++) begin
          v = 8'($urandom);
          s.push_back(v);
          x = x ^ v;
        end
        if ($urandom_range(0, 3) == 0) x = x ^ 8'($urandom_range(1, 255));
        s.push_back(x);
      end
      gap = $urandom_range(0, 2);
      model(s);
      applyStimulus(s, gap);
      checkWrites();
      checkFinal();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
